i2s_serial_mixer: RTL and testbench
===================================

Name: i2s_serial_mixer

Overview:
- Bit-serial N-channel unsigned adder (mixer) for I2S-style framed serial audio.
- Sums NCH serial words LSB-first using a multi-bit carry, one bit per falling sck edge, and latches the full-width sum with an overflow flag.
- Retransmits the previous frame's result serially on sd_out.
- Successor to the 2-input serial adder: adds parametrised channel count, a per-channel enable mask, a parallel result, framing-error detection and a one-frame-latency serial output.

Parameters:
- WIDTH, 24, bits per serial word (>=2).
- NCH, 2, number of serial input channels (2..8).
- CW (localparam), $clog2(NCH), carry width; result width is WIDTH+CW.

Ports:
- sck  input  1  serial bit clock; all state updates on its falling edge.
- reset_n  input  1  asynchronous, active-low reset.
- ws  input  1  word select; any transition starts a frame.
- sd_in  input  NCH  serial data, one bit per channel, LSB-first.
- ch_en  input  NCH  channel enable mask; latched at frame start.
- sd_out  output  1  serial result of previous frame, LSB-first.
- sum  output  WIDTH+CW  last complete frame sum.
- sum_valid  output  1  one-sck pulse when sum updates.
- ovf  output  1  sum exceeds 2^WIDTH-1; held with sum.
- frame_err  output  1  one-sck pulse when a frame is truncated.
- busy  output  1  high in ACCUM.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; ws_d, bitcnt, carry, acc, out_sr, en_q all 0.
- Edge detect: ws_d <= ws on each falling edge; ws_edge = ws ^ ws_d.
- IDLE: on ws_edge go to ACCUM; bitcnt=0, carry=0, en_q<=ch_en, out_sr<=result of last frame. First data bit is sampled on the following falling edge (one-bit I2S delay).
- ACCUM, per falling edge:
  - s = popcount(sd_in & en_q) + carry (CW+1 bits wide).
  - acc[bitcnt] <= s[0]; carry <= s>>1; bitcnt++.
- Last bit (bitcnt==WIDTH-1): on the same edge,
  - sum <= {s>>1, s[0], acc[WIDTH-2:0]}; sum_valid <= 1 for one sck.
  - ovf <= |sum[WIDTH+CW-1:WIDTH].
  - Go to IDLE.
- Width rule: maximum carry is NCH-1 < 2^CW, so the sum never loses bits.
- ws_edge in ACCUM before the last bit: frame_err pulses for 1 sck; partial acc is discarded; sum and ovf are unchanged; the frame restarts as from IDLE.
- ws_edge on the same edge as the last bit: the sum completes normally (sum_valid=1, no frame_err) and the new frame starts (stays ACCUM, bitcnt=0).
- sd_out = out_sr[0]; out_sr shifts right on every ACCUM edge, zero-fill.
  - Bit k of the previous result appears while bit k of the current frame is sampled.
  - sd_out is 0 before the first complete frame and 0 in IDLE.
- ch_en changes mid-frame have no effect until the next frame start.
- Reset mid-frame aborts immediately; no sum_valid, no frame_err.

Optional Feature:
- Macro I2S_MIXER_SAT_EN.
- Defined: the value loaded into out_sr is saturated, i.e. ovf ? all-ones(WIDTH) : sum[WIDTH-1:0].
- Undefined: out_sr loads sum[WIDTH-1:0] (wrap-around).
- sum and ovf are identical in both builds.

Decomposition:
- Package i2s_mixer_pkg:
  - state enum {IDLE, ACCUM};
  - function for CW;
  - popcount function.
- Sub-module mix_bitslice: combinational popcount(sd_in & en_q) + carry, returning sum bit and next carry. Parameterised by NCH.

Test Plan:
- WIDTH=24, NCH=2, ch_en=2'b11; ch0=0x000003, ch1=0x000005 -> sum=0x0000008, ovf=0, sum_valid 1 pulse; sd_out next frame = 0x000008 LSB-first.
- ch0=0xFFFFFF, ch1=0x000001 -> sum=0x1000000, ovf=1; sd_out next frame = 0xFFFFFF with SAT_EN, 0x000000 without.
- NCH=4, all channels 0xFFFFFF, ch_en=4'hF -> sum=0x3FFFFFC, ovf=1; ch_en=4'b0001 -> sum=0x0FFFFFF, ovf=0; ch_en toggled mid-frame has no effect.
- ws toggled after 10 bits -> frame_err pulse, no sum_valid, sum unchanged; the following full frame sums correctly.
- Back-to-back frames, ws toggling on the last-bit edge -> sum_valid each frame, no frame_err, busy stays high.
- reset_n low mid-frame -> all outputs 0 immediately; next full frame correct.

Source files
------------

// File: rtl/i2s_mixer_pkg.sv
// Shared types and helpers for the bit-serial I2S channel mixer.
package i2s_mixer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mix_state_e;

    localparam int MAX_NCH = 8;

    // Carry width needed so the running carry (at most nch-1) never overflows.
    function automatic int mix_cw(input int nch);
        return $clog2(nch);
    endfunction

    function automatic logic [3:0] popcount(input logic [MAX_NCH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mix_bitslice.sv
// One bit position of the serial mixer: counts the enabled set bits and adds
// the carry from the previous bit position.
module mix_bitslice
    import i2s_mixer_pkg::*;
#(
    parameter  int NCH = 2,
    localparam int CW  = mix_cw(NCH)
) (
    input  logic [NCH-1:0] sd_in,
    input  logic [NCH-1:0] en,
    input  logic [CW-1:0]  carry,
    output logic           sum_bit,
    output logic [CW-1:0]  carry_nx
);

    logic [MAX_NCH-1:0] active;
    logic [3:0]         cnt;
    logic [CW:0]        s;

    always_comb begin
        active            = '0;
        active[NCH-1:0]   = sd_in & en;
        cnt               = popcount(active);
        s                 = (CW+1)'(cnt) + (CW+1)'(carry);
        sum_bit           = s[0];
        carry_nx          = s[CW:1];
    end

endmodule

// File: rtl/i2s_serial_mixer.sv
// Bit-serial N-channel I2S mixer with parallel sum and one-frame-late serial replay.
// Define I2S_MIXER_SAT_EN to saturate the replayed word on overflow.
module i2s_serial_mixer
    import i2s_mixer_pkg::*;
#(
    parameter  int WIDTH = 24,
    parameter  int NCH   = 2,
    localparam int CW    = mix_cw(NCH)
) (
    input  logic                sck,
    input  logic                reset_n,
    input  logic                ws,
    input  logic [NCH-1:0]      sd_in,
    input  logic [NCH-1:0]      ch_en,
    output logic                sd_out,
    output logic [WIDTH+CW-1:0] sum,
    output logic                sum_valid,
    output logic                ovf,
    output logic                frame_err,
    output logic                busy
);

    localparam int BW = $clog2(WIDTH);
`ifdef I2S_MIXER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    mix_state_e          state, state_nx;
    logic                ws_d, ws_edge;
    logic                last_bit, frame_start, frame_done, trunc;
    logic [BW-1:0]       bitcnt;
    logic [CW-1:0]       carry, carry_nx;
    logic                sum_bit;
    logic [WIDTH-2:0]    acc;
    logic [WIDTH-1:0]    out_sr;
    logic [NCH-1:0]      en_q;
    logic [WIDTH+CW-1:0] new_sum;
    logic                new_ovf;
    logic [WIDTH-1:0]    last_word, next_word;

    function automatic logic [WIDTH-1:0] out_word(input logic [WIDTH-1:0] w, input logic o);
        return (SAT_EN && o) ? {WIDTH{1'b1}} : w;
    endfunction

    mix_bitslice #(.NCH(NCH)) u_slice (
        .sd_in    (sd_in),
        .en       (en_q),
        .carry    (carry),
        .sum_bit  (sum_bit),
        .carry_nx (carry_nx)
    );

    assign ws_edge   = ws ^ ws_d;
    assign last_bit  = (bitcnt == BW'(WIDTH - 1));
    assign new_sum   = {carry_nx, sum_bit, acc[WIDTH-2:0]};
    assign new_ovf   = |new_sum[WIDTH+CW-1:WIDTH];
    assign last_word = out_word(sum[WIDTH-1:0], ovf);
    assign next_word = out_word(new_sum[WIDTH-1:0], new_ovf);
    assign sd_out    = out_sr[0];
    assign busy      = (state == ACCUM);

    always_ff @(negedge sck or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A ws edge on the last bit both completes the frame and opens the next one.
    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        trunc       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ws_edge) begin
                    state_nx    = ACCUM;
                    frame_start = 1'b1;
                end
            end
            ACCUM: begin
                if (last_bit) begin
                    frame_done = 1'b1;
                    if (ws_edge) begin
                        frame_start = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (ws_edge) begin
                    trunc       = 1'b1;
                    frame_start = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(negedge sck or negedge reset_n) begin
        if (!reset_n) begin
            ws_d      <= 1'b0;
            bitcnt    <= '0;
            carry     <= '0;
            acc       <= '0;
            out_sr    <= '0;
            en_q      <= '0;
            sum       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ws_d      <= ws;
            sum_valid <= frame_done;
            frame_err <= trunc;
            if (frame_done) begin
                sum <= new_sum;
                ovf <= new_ovf;
            end
            if (frame_start) begin
                bitcnt <= '0;
                carry  <= '0;
                en_q   <= ch_en;
                out_sr <= frame_done ? next_word : last_word;
            end else if (state == ACCUM) begin
                out_sr <= out_sr >> 1;
                if (frame_done) begin
                    bitcnt <= '0;
                    carry  <= '0;
                end else begin
                    acc[bitcnt] <= sum_bit;
                    carry       <= carry_nx;
                    bitcnt      <= bitcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_serial_mixer.sv
// Directed + randomized bench for i2s_serial_mixer: a 2-channel and a 4-channel instance share sck/ws/reset_n.
module tb_i2s_serial_mixer;

    localparam int W = 24;
`ifdef I2S_MIXER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         sck = 1'b0;
    logic         reset_n, ws;
    logic [1:0]   sd2, en2;
    logic [3:0]   sd4, en4;
    logic         sdo2, sdo4, sv2, sv4, ov2, ov4, fe2, fe4, bz2, bz4;
    logic [W:0]   sum2;
    logic [W+1:0] sum4;

    i2s_serial_mixer #(.WIDTH(W), .NCH(2)) u2 (
        .sck(sck), .reset_n(reset_n), .ws(ws), .sd_in(sd2), .ch_en(en2),
        .sd_out(sdo2), .sum(sum2), .sum_valid(sv2), .ovf(ov2), .frame_err(fe2), .busy(bz2)
    );

    i2s_serial_mixer #(.WIDTH(W), .NCH(4)) u4 (
        .sck(sck), .reset_n(reset_n), .ws(ws), .sd_in(sd4), .ch_en(en4),
        .sd_out(sdo4), .sum(sum4), .sum_valid(sv4), .ovf(ov4), .frame_err(fe4), .busy(bz4)
    );

    always #5 sck = ~sck;

    int           nvec = 0;
    int           nfail = 0;
    logic [W:0]   m_sum2;
    logic [W+1:0] m_sum4;
    logic         m_ovf2, m_ovf4;
    logic [W-1:0] sh2, sh4;
    logic [1:0]   lat2;
    logic [3:0]   lat4;
    bit           in_frame;
    logic         nx_valid, nx_err, nx_busy, nx_sd2, nx_sd4;

    function automatic logic [W-1:0] outw(input logic [W-1:0] w, input logic o);
        return (SAT && o) ? {W{1'b1}} : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        chk("busy2", 32'(bz2), 32'(nx_busy));
        chk("busy4", 32'(bz4), 32'(nx_busy));
        chk("valid2", 32'(sv2), 32'(nx_valid));
        chk("valid4", 32'(sv4), 32'(nx_valid));
        chk("ferr2", 32'(fe2), 32'(nx_err));
        chk("ferr4", 32'(fe4), 32'(nx_err));
        chk("sdout2", 32'(sdo2), 32'(nx_sd2));
        chk("sdout4", 32'(sdo4), 32'(nx_sd4));
        chk("sum2", 32'(sum2), 32'(m_sum2));
        chk("sum4", 32'(sum4), 32'(m_sum4));
        chk("ovf2", 32'(ov2), 32'(m_ovf2));
        chk("ovf4", 32'(ov4), 32'(m_ovf4));
    endtask

    task automatic model_clear();
        m_sum2 = '0; m_sum4 = '0; m_ovf2 = 1'b0; m_ovf4 = 1'b0;
        sh2 = '0; sh4 = '0; in_frame = 1'b0;
        nx_valid = 1'b0; nx_err = 1'b0; nx_busy = 1'b0; nx_sd2 = 1'b0; nx_sd4 = 1'b0;
    endtask

    task automatic idle(input int n);
        nx_valid = 1'b0; nx_err = 1'b0; nx_busy = 1'b0; nx_sd2 = 1'b0; nx_sd4 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Plays one frame of nbits bits; the sum is the plain arithmetic total of the enabled words.
    task automatic do_frame(input logic [W-1:0] a2 [2], input logic [W-1:0] a4 [4],
                            input logic [1:0] e2, input logic [3:0] e4,
                            input int nbits, input bit started, input bit toggle_last);
        longint t2, t4;
        if (!started) begin
            ws = ~ws; en2 = e2; en4 = e4; sd2 = '0; sd4 = '0;
            lat2 = e2; lat4 = e4;
            sh2 = outw(m_sum2[W-1:0], m_ovf2);
            sh4 = outw(m_sum4[W-1:0], m_ovf4);
            nx_err = in_frame; nx_valid = 1'b0; nx_busy = 1'b1;
            nx_sd2 = sh2[0]; nx_sd4 = sh4[0];
            in_frame = 1'b1;
            tick();
        end
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < 2; c++) sd2[c] = a2[c][k];
            for (int c = 0; c < 4; c++) sd4[c] = a4[c][k];
            if (k == 3) begin en2 = 2'($urandom); en4 = 4'($urandom); end
            if (k == 8) begin en2 = e2; en4 = e4; end
            nx_err = 1'b0;
            if (k == W - 1) begin
                t2 = 0; t4 = 0;
                for (int c = 0; c < 2; c++) if (lat2[c]) t2 += longint'(a2[c]);
                for (int c = 0; c < 4; c++) if (lat4[c]) t4 += longint'(a4[c]);
                m_sum2 = t2[W:0];   m_ovf2 = (t2 >= (longint'(1) << W));
                m_sum4 = t4[W+1:0]; m_ovf4 = (t4 >= (longint'(1) << W));
                nx_valid = 1'b1;
                if (toggle_last) begin
                    ws = ~ws; lat2 = en2; lat4 = en4;
                    sh2 = outw(m_sum2[W-1:0], m_ovf2);
                    sh4 = outw(m_sum4[W-1:0], m_ovf4);
                    nx_busy = 1'b1; nx_sd2 = sh2[0]; nx_sd4 = sh4[0];
                    in_frame = 1'b1;
                end else begin
                    nx_busy = 1'b0; nx_sd2 = 1'b0; nx_sd4 = 1'b0;
                    in_frame = 1'b0;
                end
            end else begin
                nx_valid = 1'b0; nx_busy = 1'b1;
                nx_sd2 = sh2[k+1]; nx_sd4 = sh4[k+1];
            end
            tick();
        end
    endtask

    initial begin
        logic [W-1:0] a2 [2];
        logic [W-1:0] a4 [4];

        reset_n = 1'b0; ws = 1'b0; sd2 = '0; sd4 = '0; en2 = '0; en4 = '0;
        lat2 = '0; lat4 = '0;
        model_clear();
        tick(); tick();
        reset_n = 1'b1;
        idle(3);

        a2 = '{24'h000003, 24'h000005};
        a4 = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        do_frame(a2, a4, 2'b11, 4'hF, W, 1'b0, 1'b0);
        idle(2);

        a2 = '{24'hFFFFFF, 24'h000001};
        do_frame(a2, a4, 2'b11, 4'b0001, W, 1'b0, 1'b0);
        idle(2);

        for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
        for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
        do_frame(a2, a4, 2'b11, 4'hF, W, 1'b0, 1'b0);
        idle(1);

        for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
        for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
        do_frame(a2, a4, 2'b11, 4'hF, 10, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
        do_frame(a2, a4, 2'b11, 4'b1010, W, 1'b0, 1'b0);
        idle(2);

        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
            for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
            do_frame(a2, a4, 2'b11, 4'b0111, W, f != 0, f != 2);
        end
        idle(2);

        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
            for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
            do_frame(a2, a4, 2'($urandom), 4'($urandom), W, 1'b0, 1'b0);
            idle(1);
        end

        for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
        for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
        do_frame(a2, a4, 2'b11, 4'hF, 7, 1'b0, 1'b0);
        reset_n = 1'b0; ws = 1'b0;
        #1;
        chk("rst_sum2", 32'(sum2), 32'd0);
        chk("rst_sum4", 32'(sum4), 32'd0);
        chk("rst_busy2", 32'(bz2), 32'd0);
        chk("rst_busy4", 32'(bz4), 32'd0);
        chk("rst_sdout2", 32'(sdo2), 32'd0);
        chk("rst_flags4", 32'({sv4, ov4, fe4, sdo4}), 32'd0);
        model_clear();
        tick();
        reset_n = 1'b1;
        idle(2);
        for (int c = 0; c < 2; c++) a2[c] = W'($urandom);
        for (int c = 0; c < 4; c++) a4[c] = W'($urandom);
        do_frame(a2, a4, 2'b11, 4'hF, W, 1'b0, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
